// File: rtl/osc_seq_pkg.sv
// Shared types and 50 MHz default timing for the oscillator power-up sequencer.
package osc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAM_RST  = 3'd1,
    ST_CAM_WAKE = 3'd2,
    ST_LCD_RST  = 3'd3,
    ST_INIT     = 3'd4,
    ST_RUN      = 3'd5,
    ST_FAULT    = 3'd6
  } state_e;

  typedef struct packed {
    logic fabric_rst;
    logic cam_pwdn;
    logic cam_resetn;
    logic lcd_resetn;
    logic init_start;
    logic bl_en;
    logic ready;
    logic fault;
  } seq_out_t;

  localparam seq_out_t SEQ_OUT_RST = '{fabric_rst: 1'b1, cam_pwdn: 1'b1, default: 1'b0};

  localparam int DEF_LOCK_FILT_CYC    = 1024;
  localparam int DEF_CAM_RST_CYC      = 50000;
  localparam int DEF_CAM_WAKE_CYC     = 50000;
  localparam int DEF_LCD_RST_CYC      = 500000;
  localparam int DEF_INIT_TIMEOUT_CYC = 5000000;
  localparam int DEF_MAX_RETRY        = 2;
  localparam int DEF_CNT_W            = 24;

endpackage

// File: rtl/osc_seq_timer.sv
// Loadable down-counter shared by every timed state and the init timeout.
module osc_seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                value_q <= '0;
    else if (load_i)          value_q <= load_val_i;
    else if (value_q != '0)   value_q <= value_q - 1'b1;
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/osc_pwrup_sequencer.sv
// Waits for a filtered CCC lock, then sequences camera/LCD reset, init and backlight,
// restarting on lock loss and latching FAULT once init retries run out.
module osc_pwrup_sequencer
  import osc_seq_pkg::*;
#(
  parameter int LOCK_FILT_CYC    = DEF_LOCK_FILT_CYC,
  parameter int CAM_RST_CYC      = DEF_CAM_RST_CYC,
  parameter int CAM_WAKE_CYC     = DEF_CAM_WAKE_CYC,
  parameter int LCD_RST_CYC      = DEF_LCD_RST_CYC,
  parameter int INIT_TIMEOUT_CYC = DEF_INIT_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CCC_LOCK,
  input  logic       INIT_DONE,
  input  logic       INIT_ERR,
  output logic       FABRIC_RST,
  output logic       CAM_PWDN,
  output logic       CAM_RESETN,
  output logic       LCD_RESETN,
  output logic       INIT_START,
  output logic       BL_EN,
  output logic       READY,
  output logic       FAULT,
  output logic [2:0] STATE
);

  localparam int LW = $clog2(LOCK_FILT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_e           state_q, state_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic [RW-1:0]    retry_q, retry_d;
  seq_out_t         out_q, out_d;
  logic             init_fail;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_ld_val, tmr_value;
  logic             tmr_value_unused;

  osc_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_ld_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  assign tmr_value_unused = ^tmr_value;

  always_comb begin
    state_d   = state_q;
    lock_d    = '0;
    retry_d   = retry_q;
    init_fail = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        retry_d = '0;
        if (CCC_LOCK) begin
          lock_d = (lock_q == LW'(LOCK_FILT_CYC)) ? lock_q : lock_q + 1'b1;
          if (lock_q >= LW'(LOCK_FILT_CYC - 1)) state_d = ST_CAM_RST;
        end
      end
      ST_CAM_RST:  if (tmr_zero) state_d = ST_CAM_WAKE;
      ST_CAM_WAKE: if (tmr_zero) state_d = ST_LCD_RST;
      ST_LCD_RST:  if (tmr_zero) state_d = ST_INIT;
      ST_INIT: begin
        // init_start_q marks the first INIT cycle, whose DONE/ERR sample is ignored
        if (!out_q.init_start && INIT_ERR)       init_fail = 1'b1;
        else if (!out_q.init_start && INIT_DONE) state_d   = ST_RUN;
        else if (tmr_zero)                       init_fail = 1'b1;
        if (init_fail) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_CAM_RST;
          end else begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_RUN:   retry_d = '0;
      ST_FAULT: ;
      default:  state_d = ST_IDLE;
    endcase
    if (!CCC_LOCK && state_q != ST_IDLE && state_q != ST_FAULT) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end
  end

  // Timer reloads on every state change; untimed states park it at zero.
  assign tmr_load = (state_d != state_q);

  always_comb begin
    unique case (state_d)
      ST_CAM_RST:  tmr_ld_val = CNT_W'(CAM_RST_CYC - 1);
      ST_CAM_WAKE: tmr_ld_val = CNT_W'(CAM_WAKE_CYC - 1);
      ST_LCD_RST:  tmr_ld_val = CNT_W'(LCD_RST_CYC - 1);
      ST_INIT:     tmr_ld_val = CNT_W'(INIT_TIMEOUT_CYC - 1);
      default:     tmr_ld_val = '0;
    endcase
  end

  always_comb begin
    out_d = SEQ_OUT_RST;
    unique case (state_d)
      ST_CAM_RST: begin
        out_d.fabric_rst = 1'b0;
        out_d.cam_pwdn   = 1'b0;
      end
      ST_CAM_WAKE, ST_LCD_RST: begin
        out_d.fabric_rst = 1'b0;
        out_d.cam_pwdn   = 1'b0;
        out_d.cam_resetn = 1'b1;
      end
      ST_INIT, ST_RUN: begin
        out_d.fabric_rst = 1'b0;
        out_d.cam_pwdn   = 1'b0;
        out_d.cam_resetn = 1'b1;
        out_d.lcd_resetn = 1'b1;
        out_d.init_start = (state_d == ST_INIT) && (state_q != ST_INIT);
        out_d.bl_en      = (state_d == ST_RUN);
        out_d.ready      = (state_d == ST_RUN);
      end
      ST_FAULT: begin
        out_d.fabric_rst = 1'b0;
        out_d.fault      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      retry_q <= '0;
      out_q   <= SEQ_OUT_RST;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign FABRIC_RST = out_q.fabric_rst;
  assign CAM_PWDN   = out_q.cam_pwdn;
  assign CAM_RESETN = out_q.cam_resetn;
  assign LCD_RESETN = out_q.lcd_resetn;
  assign INIT_START = out_q.init_start;
  assign BL_EN      = out_q.bl_en;
  assign READY      = out_q.ready;
  assign FAULT      = out_q.fault;
  assign STATE      = state_q;

endmodule
